// File: rtl/um_alu_fsm_pkg.sv
// Shared opcodes, state encoding and bus packing for the UM register-only ALU sequencer.
package um_alu_fsm_pkg;

  localparam int unsigned OP_CMOV = 0;
  localparam int unsigned OP_ADD  = 3;
  localparam int unsigned OP_MUL  = 4;
  localparam int unsigned OP_DIV  = 5;
  localparam int unsigned OP_NAND = 6;

  typedef enum logic [2:0] {
    IDLE,
    RD_C,
    RD_B,
    EXEC,
    DIV,
    WR_A,
    DONE
  } um_alu_state_t;

  // Register bus as seen by reg_in_bus_buf in the 32-bit, 8-register configuration.
  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] data;
    logic        mode;
  } reg_in_bus_t;

  function automatic logic is_legal_op(input logic [31:0] op);
    return (op == OP_CMOV) || (op == OP_ADD) || (op == OP_MUL) ||
           (op == OP_DIV)  || (op == OP_NAND);
  endfunction

endpackage

// File: rtl/um_alu_fsm_iter_divider.sv
// Unsigned restoring divider producing one quotient bit per clock over DATA_W clocks.
module um_iter_divider #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] dsr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W:0]   trial;
  logic [DATA_W:0]   diff;

  // The dividend shifts out of the quotient register MSB-first while quotient bits shift in.
  always_comb begin
    trial = {rem, quotient[DATA_W-1]};
    diff  = trial - {1'b0, dsr};
  end

  // done flags the final step; the finished quotient is visible right after this edge.
  assign done = (count == CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem      <= '0;
      dsr      <= '0;
      quotient <= '0;
      count    <= '0;
    end else if (start) begin
      rem      <= '0;
      dsr      <= divisor;
      quotient <= dividend;
      count    <= CNT_W'(DATA_W);
    end else if (count != '0) begin
      count <= count - 1'b1;
      if (!diff[DATA_W]) begin
        rem      <= diff[DATA_W-1:0];
        quotient <= {quotient[DATA_W-2:0], 1'b1};
      end else begin
        rem      <= trial[DATA_W-1:0];
        quotient <= {quotient[DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/um_alu_fsm.sv
// Sequencer for the UM register-only operations (cmov, add, mul, div, nand) with a
// start/finished handshake, driving reg_bank reads and the single write-back.
module um_alu_fsm
  import um_alu_fsm_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_SEL_W = 3,
  parameter int OPCODE_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic [REG_SEL_W-1:0] reg_a,
  input  logic [REG_SEL_W-1:0] reg_b,
  input  logic [REG_SEL_W-1:0] reg_c,
  input  logic [DATA_W-1:0]    reg_rdata,
  output logic [REG_SEL_W-1:0] reg_sel,
  output logic [DATA_W-1:0]    reg_wdata,
  output logic                 reg_we,
  output logic                 busy,
  output logic                 finished,
  output logic                 fault
);

  um_alu_state_t state, next_state;

  logic [OPCODE_W-1:0]  op_q;
  logic [REG_SEL_W-1:0] a_q, b_q, c_q;
  logic [DATA_W-1:0]    opb, opc, result, alu_out;
  logic [DATA_W-1:0]    div_quotient;
  logic                 div_start, div_done;
  logic                 start_legal;
  logic                 is_cmov, is_add, is_mul, is_div, is_nand;

  assign start_legal = is_legal_op(32'(opcode));
  assign is_cmov     = (op_q == OPCODE_W'(OP_CMOV));
  assign is_add      = (op_q == OPCODE_W'(OP_ADD));
  assign is_mul      = (op_q == OPCODE_W'(OP_MUL));
  assign is_div      = (op_q == OPCODE_W'(OP_DIV));
  assign is_nand     = (op_q == OPCODE_W'(OP_NAND));

  // Divisor comes from the register read a cycle earlier, dividend straight off the bus.
  assign div_start = (state == RD_B) && is_div && (opc != '0);

  um_iter_divider #(
    .DATA_W (DATA_W)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (reg_rdata),
    .divisor  (opc),
    .quotient (div_quotient),
    .done     (div_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = start_legal ? RD_C : DONE;
      RD_C: next_state = RD_B;
      RD_B: begin
        if (is_div) next_state = (opc == '0) ? DONE : DIV;
        else        next_state = EXEC;
      end
      EXEC: next_state = (is_cmov && (opc == '0)) ? DONE : WR_A;
      DIV:  if (div_done) next_state = WR_A;
      WR_A: next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    reg_sel   = '0;
    reg_we    = 1'b0;
    reg_wdata = '0;
    busy      = 1'b0;
    finished  = 1'b0;
    case (state)
      RD_C: begin
        reg_sel = c_q;
        busy    = 1'b1;
      end
      RD_B: begin
        reg_sel = b_q;
        busy    = 1'b1;
      end
      EXEC: busy = 1'b1;
      DIV:  busy = 1'b1;
      WR_A: begin
        reg_sel   = a_q;
        reg_we    = 1'b1;
        reg_wdata = is_div ? div_quotient : result;
        busy      = 1'b1;
      end
      DONE: finished = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    alu_out = opb;
    if (is_add)  alu_out = opb + opc;
    if (is_mul)  alu_out = opb * opc;
    if (is_nand) alu_out = ~(opb & opc);
  end

  // Operands are captured before any write, so self-referencing instructions see old values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      opb    <= '0;
      opc    <= '0;
      result <= '0;
      fault  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= opcode;
            a_q   <= reg_a;
            b_q   <= reg_b;
            c_q   <= reg_c;
            fault <= !start_legal;
          end
        end
        RD_C: opc <= reg_rdata;
        RD_B: begin
          opb <= reg_rdata;
          if (is_div && (opc == '0)) fault <= 1'b1;
        end
        EXEC: result <= alu_out;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_um_alu_fsm.sv
// Scoreboarded bench for um_alu_fsm: a 32-bit instance and an 8-bit/16-register instance.
module tb_um_alu_fsm;
  import um_alu_fsm_pkg::*;

  typedef struct packed {
    logic [7:0]  writes;
    logic [7:0]  wr_cycle;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [7:0]  fin;
    logic        flt;
    logic        busy1;
    logic        busy_fin;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic [3:0]  opcode;
  logic [2:0]  reg_a, reg_b, reg_c;
  logic [31:0] reg_rdata;
  logic [2:0]  reg_sel;
  logic [31:0] reg_wdata;
  logic        reg_we, busy, finished, fault;

  logic        p_start;
  logic [3:0]  p_opcode;
  logic [3:0]  p_reg_a, p_reg_b, p_reg_c;
  logic [7:0]  p_reg_rdata;
  logic [3:0]  p_reg_sel;
  logic [7:0]  p_reg_wdata;
  logic        p_reg_we, p_busy, p_finished, p_fault;

  logic [31:0] bank [8];
  logic [7:0]  p_bank [16];
  logic        pre_we, p_pre_we;
  logic [2:0]  pre_sel;
  logic [3:0]  p_pre_sel;
  logic [31:0] pre_data;
  logic [7:0]  p_pre_data;
  int          write_cnt = 0;

  int   checks = 0;
  int   failures = 0;
  res_t obs;
  res_t exp_q[$];

  um_alu_fsm dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c), .reg_rdata(reg_rdata),
    .reg_sel(reg_sel), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .busy(busy), .finished(finished), .fault(fault)
  );

  um_alu_fsm #(.DATA_W(8), .REG_SEL_W(4), .OPCODE_W(4)) dut_p (
    .clk(clk), .reset(reset), .start(p_start), .opcode(p_opcode),
    .reg_a(p_reg_a), .reg_b(p_reg_b), .reg_c(p_reg_c), .reg_rdata(p_reg_rdata),
    .reg_sel(p_reg_sel), .reg_wdata(p_reg_wdata), .reg_we(p_reg_we),
    .busy(p_busy), .finished(p_finished), .fault(p_fault)
  );

  assign reg_rdata   = bank[reg_sel];
  assign p_reg_rdata = p_bank[p_reg_sel];

  always @(posedge clk) begin
    if (pre_we) bank[pre_sel] <= pre_data;
    else if (reg_we) bank[reg_sel] <= reg_wdata;
    if (p_pre_we) p_bank[p_pre_sel] <= p_pre_data;
    else if (p_reg_we) p_bank[p_reg_sel] <= p_reg_wdata;
    if (reg_we) write_cnt <= write_cnt + 1;
  end

  function automatic res_t make_exp(input int writes, input int wr_cycle, input logic [3:0] sel,
                                    input logic [31:0] data, input int fin, input logic flt,
                                    input logic busy1);
    res_t r;
    r.writes   = 8'(writes);
    r.wr_cycle = 8'(wr_cycle);
    r.sel      = sel;
    r.data     = data;
    r.fin      = 8'(fin);
    r.flt      = flt;
    r.busy1    = busy1;
    r.busy_fin = 1'b0;
    return r;
  endfunction

  task automatic set_reg(input logic [2:0] s, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_sel = s; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic set_reg_p(input logic [3:0] s, input logic [7:0] d);
    @(negedge clk);
    p_pre_we = 1'b1; p_pre_sel = s; p_pre_data = d;
    @(negedge clk);
    p_pre_we = 1'b0;
  endtask

  // Drives one instruction and records what the DUT does, cycle 0 being the start cycle.
  task automatic apply_stimulus(input logic [3:0] op, input logic [2:0] a, b, c, input int extra_at);
    obs = '0;
    obs.wr_cycle = 8'hFF;
    obs.fin = 8'hFF;
    @(negedge clk);
    start = 1'b1; opcode = op; reg_a = a; reg_b = b; reg_c = c;
    for (int k = 1; k <= 60 && obs.fin == 8'hFF; k++) begin
      @(negedge clk);
      if (k == extra_at) begin
        start = 1'b1; opcode = 4'(OP_MUL); reg_a = 3'd5; reg_b = 3'd6; reg_c = 3'd7;
      end else begin
        start = 1'b0;
      end
      if (k == 1) obs.busy1 = busy;
      if (reg_we) begin
        obs.writes = obs.writes + 8'd1; obs.wr_cycle = 8'(k);
        obs.sel = {1'b0, reg_sel}; obs.data = reg_wdata;
      end
      if (finished) begin
        obs.fin = 8'(k); obs.flt = fault; obs.busy_fin = busy;
      end
    end
    start = 1'b0;
  endtask

  task automatic apply_stimulus_p(input logic [3:0] op, input logic [3:0] a, b, c);
    obs = '0;
    obs.wr_cycle = 8'hFF;
    obs.fin = 8'hFF;
    @(negedge clk);
    p_start = 1'b1; p_opcode = op; p_reg_a = a; p_reg_b = b; p_reg_c = c;
    for (int k = 1; k <= 60 && obs.fin == 8'hFF; k++) begin
      @(negedge clk);
      p_start = 1'b0;
      if (k == 1) obs.busy1 = p_busy;
      if (p_reg_we) begin
        obs.writes = obs.writes + 8'd1; obs.wr_cycle = 8'(k);
        obs.sel = p_reg_sel; obs.data = {24'h0, p_reg_wdata};
      end
      if (p_finished) begin
        obs.fin = 8'(k); obs.flt = p_fault; obs.busy_fin = p_busy;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({reg_sel, reg_we, reg_wdata, busy, finished, fault,
         p_reg_sel, p_reg_we, p_reg_wdata, p_busy, p_finished, p_fault} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h exp=0", {reg_sel, reg_we, reg_wdata, busy, finished, fault});
    end
    reset = 1'b1;
  endtask

  task automatic test_add_wrap;
    res_t e;
    set_reg(3'd2, 32'hFFFF_FFFF); set_reg(3'd4, 32'h2); set_reg(3'd1, 32'h0);
    exp_q.push_back(make_exp(1, 4, 4'd1, 32'h1, 5, 1'b0, 1'b1));
    apply_stimulus(4'(OP_ADD), 3'd1, 3'd2, 3'd4, 0);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin failures++; $display("[TB] FAIL add_wrap got=%h exp=%h", obs, e); end
    checks++;
    if (bank[1] !== 32'h1) begin failures++; $display("[TB] FAIL add_wrap_r1 got=%h exp=%h", bank[1], 32'h1); end
  endtask

  task automatic test_cmov;
    res_t e;
    set_reg(3'd1, 32'h1111); set_reg(3'd4, 32'h0); set_reg(3'd2, 32'h5555);
    exp_q.push_back(make_exp(0, 255, 4'd0, 32'h0, 4, 1'b0, 1'b1));
    apply_stimulus(4'(OP_CMOV), 3'd1, 3'd2, 3'd4, 0);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin failures++; $display("[TB] FAIL cmov_zero got=%h exp=%h", obs, e); end
    checks++;
    if (bank[1] !== 32'h1111) begin failures++; $display("[TB] FAIL cmov_zero_r1 got=%h exp=%h", bank[1], 32'h1111); end
    set_reg(3'd4, 32'hCCCC);
    exp_q.push_back(make_exp(1, 4, 4'd1, 32'h5555, 5, 1'b0, 1'b1));
    apply_stimulus(4'(OP_CMOV), 3'd1, 3'd2, 3'd4, 0);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin failures++; $display("[TB] FAIL cmov_move got=%h exp=%h", obs, e); end
    checks++;
    if (bank[1] !== 32'h5555) begin failures++; $display("[TB] FAIL cmov_move_r1 got=%h exp=%h", bank[1], 32'h5555); end
  endtask

  task automatic test_div;
    res_t e;
    set_reg(3'd2, 32'h5555); set_reg(3'd4, 32'h3);
    exp_q.push_back(make_exp(1, 35, 4'd1, 32'h1C71, 36, 1'b0, 1'b1));
    apply_stimulus(4'(OP_DIV), 3'd1, 3'd2, 3'd4, 0);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin failures++; $display("[TB] FAIL div got=%h exp=%h", obs, e); end
    set_reg(3'd4, 32'h0);
    exp_q.push_back(make_exp(0, 255, 4'd0, 32'h0, 3, 1'b1, 1'b1));
    apply_stimulus(4'(OP_DIV), 3'd1, 3'd2, 3'd4, 0);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin failures++; $display("[TB] FAIL div_by_zero got=%h exp=%h", obs, e); end
  endtask

  task automatic test_nand_mul;
    res_t e;
    set_reg(3'd2, 32'hCCCC); set_reg(3'd4, 32'hFFFF_FFFF);
    exp_q.push_back(make_exp(1, 4, 4'd1, 32'hFFFF_3333, 5, 1'b0, 1'b1));
    apply_stimulus(4'(OP_NAND), 3'd1, 3'd2, 3'd4, 0);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin failures++; $display("[TB] FAIL nand got=%h exp=%h", obs, e); end
    set_reg(3'd2, 32'h10000); set_reg(3'd4, 32'h10000);
    exp_q.push_back(make_exp(1, 4, 4'd1, 32'h0, 5, 1'b0, 1'b1));
    apply_stimulus(4'(OP_MUL), 3'd1, 3'd2, 3'd4, 0);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin failures++; $display("[TB] FAIL mul_wrap got=%h exp=%h", obs, e); end
    set_reg(3'd2, 32'h1234); set_reg(3'd4, 32'h10);
    exp_q.push_back(make_exp(1, 4, 4'd1, 32'h12340, 5, 1'b0, 1'b1));
    apply_stimulus(4'(OP_MUL), 3'd1, 3'd2, 3'd4, 0);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin failures++; $display("[TB] FAIL mul got=%h exp=%h", obs, e); end
  endtask

  task automatic test_illegal;
    res_t e;
    exp_q.push_back(make_exp(0, 255, 4'd0, 32'h0, 1, 1'b1, 1'b0));
    apply_stimulus(4'd7, 3'd1, 3'd2, 3'd4, 0);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin failures++; $display("[TB] FAIL illegal_op got=%h exp=%h", obs, e); end
    repeat (2) @(negedge clk);
    checks++;
    if (fault !== 1'b1) begin failures++; $display("[TB] FAIL fault_sticky got=%b exp=1", fault); end
  endtask

  task automatic test_back_to_back;
    res_t e;
    set_reg(3'd5, 32'h5A5A); set_reg(3'd2, 32'd100); set_reg(3'd4, 32'd23);
    exp_q.push_back(make_exp(1, 4, 4'd1, 32'd123, 5, 1'b0, 1'b1));
    apply_stimulus(4'(OP_ADD), 3'd1, 3'd2, 3'd4, 2);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin failures++; $display("[TB] FAIL start_while_busy got=%h exp=%h", obs, e); end
    checks++;
    if (bank[5] !== 32'h5A5A) begin failures++; $display("[TB] FAIL start_while_busy_r5 got=%h exp=%h", bank[5], 32'h5A5A); end
  endtask

  task automatic test_self_ref;
    res_t e;
    set_reg(3'd2, 32'd7);
    exp_q.push_back(make_exp(1, 4, 4'd2, 32'd14, 5, 1'b0, 1'b1));
    apply_stimulus(4'(OP_ADD), 3'd2, 3'd2, 3'd2, 0);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e || bank[2] !== 32'd14) begin
      failures++; $display("[TB] FAIL self_ref got=%h exp=%h r2=%h", obs, e, bank[2]);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] x, y, d;
      logic [3:0]  op;
      int          fin;
      res_t        e;
      fin = 5;
      x = $urandom;
      case ($urandom_range(0, 3))
        0: begin op = 4'(OP_ADD); y = $urandom; d = x + y; end
        1: begin op = 4'(OP_MUL); y = $urandom; d = x * y; end
        2: begin op = 4'(OP_NAND); y = $urandom; d = ~(x & y); end
        default: begin op = 4'(OP_DIV); y = $urandom_range(1, 65535); d = x / y; fin = 36; end
      endcase
      set_reg(3'd2, x); set_reg(3'd4, y);
      exp_q.push_back(make_exp(1, fin - 1, 4'd1, d, fin, 1'b0, 1'b1));
      apply_stimulus(op, 3'd1, 3'd2, 3'd4, 0);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("[TB] FAIL random_%0d op=%0d got=%h exp=%h", i, op, obs, e); end
    end
  endtask

  task automatic test_reset_mid_div;
    int wc;
    set_reg(3'd1, 32'hABCD); set_reg(3'd2, 32'h5555); set_reg(3'd4, 32'h3);
    wc = write_cnt;
    @(negedge clk);
    start = 1'b1; opcode = 4'(OP_DIV); reg_a = 3'd1; reg_b = 3'd2; reg_c = 3'd4;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL div_in_flight got=%b exp=1", busy); end
    reset = 1'b0;
    #1;
    checks++;
    if ({reg_sel, reg_we, reg_wdata, busy, finished, fault} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_mid_div got=%h exp=0", {reg_sel, reg_we, reg_wdata, busy, finished, fault});
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (45) @(negedge clk);
    checks++;
    if (write_cnt !== wc || bank[1] !== 32'hABCD) begin
      failures++; $display("[TB] FAIL reset_no_write got=%0d/%h exp=%0d/%h", write_cnt, bank[1], wc, 32'hABCD);
    end
  endtask

  task automatic test_param;
    res_t e;
    set_reg_p(4'd9, 8'hF0); set_reg_p(4'd15, 8'h20);
    exp_q.push_back(make_exp(1, 4, 4'd3, 32'h10, 5, 1'b0, 1'b1));
    apply_stimulus_p(4'(OP_ADD), 4'd3, 4'd9, 4'd15);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e || p_bank[3] !== 8'h10) begin
      failures++; $display("[TB] FAIL param_add got=%h exp=%h r3=%h", obs, e, p_bank[3]);
    end
    set_reg_p(4'd9, 8'hFF); set_reg_p(4'd15, 8'h10);
    exp_q.push_back(make_exp(1, 11, 4'd3, 32'h0F, 12, 1'b0, 1'b1));
    apply_stimulus_p(4'(OP_DIV), 4'd3, 4'd9, 4'd15);
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin failures++; $display("[TB] FAIL param_div got=%h exp=%h", obs, e); end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0; opcode = '0; reg_a = '0; reg_b = '0; reg_c = '0;
    p_start = 1'b0; p_opcode = '0; p_reg_a = '0; p_reg_b = '0; p_reg_c = '0;
    pre_we = 1'b0; pre_sel = '0; pre_data = '0;
    p_pre_we = 1'b0; p_pre_sel = '0; p_pre_data = '0;
    test_reset();
    test_add_wrap();
    test_cmov();
    test_div();
    test_nand_mul();
    test_illegal();
    test_back_to_back();
    test_self_ref();
    test_random();
    test_reset_mid_div();
    test_param();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
